// File: rtl/axi4_lite_slave_shared.sv
// AXI4-Lite slave funnelling reads and writes onto one shared register-bank port.
// Optional access timeout enabled by defining AXI4_LITE_SLAVE_SHARED_TIMEOUT_EN.
module axi4_lite_slave_shared #(
   parameter int              addr_width     = 7,
   parameter int              data_width     = 32,
   parameter longint unsigned addr_limit     = 64'd1 << addr_width,
   parameter int              timeout_cycles = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      access_req,
   output logic                      access_write,
   output logic [addr_width-1:0]     access_addr,
   output logic [data_width-1:0]     access_wdata,
   output logic [data_width/8-1:0]   access_wstrb,
   input  logic                      access_ready,
   input  logic                      access_error,
   input  logic [data_width-1:0]     access_rdata,
   input  logic [addr_width-1:0]     s_axi_awaddr,
   input  logic [2:0]                s_axi_awprot,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [data_width-1:0]     s_axi_wdata,
   input  logic [data_width/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [addr_width-1:0]     s_axi_araddr,
   input  logic [2:0]                s_axi_arprot,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [data_width-1:0]     s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready
);

   localparam int                    lsb_w    = $clog2(data_width / 8);
   localparam logic [addr_width-1:0] lsb_mask = addr_width'((1 << lsb_w) - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, BRESP, RRESP} state_t;

   state_t                    state, state_next;
   logic                      last_grant_write;
   logic                      write_q;
   logic [addr_width-1:0]     addr_q;
   logic [data_width-1:0]     wdata_q;
   logic [data_width/8-1:0]   wstrb_q;
   logic [data_width-1:0]     rdata_q;
   logic [1:0]                resp_q;

   logic                      rd_pend, wr_pend, grant_wr, grant_rd;
   logic [addr_width-1:0]     addr_masked;
   logic                      dec_err, timeout_hit;

   logic unused_prot;
   assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

   // Round-robin: on contention, the side not served last wins.
   assign rd_pend     = s_axi_arvalid;
   assign wr_pend     = s_axi_awvalid && s_axi_wvalid;
   assign grant_wr    = wr_pend && (!rd_pend || !last_grant_write);
   assign grant_rd    = rd_pend && (!wr_pend || last_grant_write);
   assign addr_masked = (grant_wr ? s_axi_awaddr : s_axi_araddr) & ~lsb_mask;
   assign dec_err     = 64'(addr_masked) >= addr_limit;

`ifdef AXI4_LITE_SLAVE_SHARED_TIMEOUT_EN
   localparam int cnt_w = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
   logic [cnt_w-1:0] wait_cnt;

   assign timeout_hit = (state == ACCESS) && !access_ready &&
                        (wait_cnt == cnt_w'(timeout_cycles - 1));

   always_ff @(posedge clk) begin
      if (rst || state == IDLE) wait_cnt <= '0;
      else if (state == ACCESS && !access_ready) wait_cnt <= wait_cnt + 1'b1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(timeout_cycles);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_next    = state;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_arready = 1'b0;
      case (state)
         IDLE: if (!rst) begin
            if (grant_wr) begin
               s_axi_awready = 1'b1;
               s_axi_wready  = 1'b1;
               state_next    = dec_err ? BRESP : ACCESS;
            end else if (grant_rd) begin
               s_axi_arready = 1'b1;
               state_next    = dec_err ? RRESP : ACCESS;
            end
         end
         ACCESS: if (access_ready || timeout_hit) state_next = write_q ? BRESP : RRESP;
         BRESP:  if (s_axi_bready) state_next = IDLE;
         RRESP:  if (s_axi_rready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_write <= 1'b1;
         write_q          <= 1'b0;
         addr_q           <= '0;
         wdata_q          <= '0;
         wstrb_q          <= '0;
         rdata_q          <= '0;
         resp_q           <= 2'b00;
      end else if (state == IDLE) begin
         if (grant_wr || grant_rd) begin
            last_grant_write <= grant_wr;
            write_q          <= grant_wr;
            addr_q           <= addr_masked;
            wdata_q          <= grant_wr ? s_axi_wdata : '0;
            wstrb_q          <= grant_wr ? s_axi_wstrb : '0;
            rdata_q          <= '0;
            resp_q           <= dec_err ? 2'b11 : 2'b00;
         end
      end else if (state == ACCESS) begin
         if (access_ready) begin
            rdata_q <= access_rdata;
            resp_q  <= access_error ? 2'b10 : 2'b00;
         end else if (timeout_hit) begin
            rdata_q <= '0;
            resp_q  <= 2'b10;
         end
      end
   end

   assign access_req   = (state == ACCESS);
   assign access_write = write_q;
   assign access_addr  = addr_q;
   assign access_wdata = wdata_q;
   assign access_wstrb = wstrb_q;
   assign s_axi_bvalid = (state == BRESP);
   assign s_axi_bresp  = resp_q;
   assign s_axi_rvalid = (state == RRESP);
   assign s_axi_rresp  = resp_q;
   assign s_axi_rdata  = rdata_q;

endmodule
